// File: rtl/bcd_updown_counter.sv
// Up/down BCD counter with parallel load, terminal value and cascade flags; count latency 1.
// No backpressure: one step per cycle while en_i is high; wrap/error flags are combinational.
module bcd_updown_counter #(
    parameter int NUM_DIGITS = 2,
    parameter int MAX_COUNT  = 59,
    parameter int BW         = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    down_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] load_value_i,
    output logic [4*NUM_DIGITS-1:0] count_o,
    output logic [BW-1:0]           count_bin_o,
    output logic                    overflow_o,
    output logic                    underflow_o,
    output logic                    load_err_o
);
    localparam int CW = 4 * NUM_DIGITS;

    function automatic logic [CW-1:0] int_to_bcd(input int v);
        int r;
        r = v;
        int_to_bcd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            int_to_bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    localparam logic [CW-1:0] MAX_BCD = int_to_bcd(MAX_COUNT);

    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] count_bin_q, count_bin_d;
    logic [CW-1:0] inc_bcd, dec_bcd;
    logic          carry, borrow;
    logic [16:0]   load_bin;
    logic          nib_bad, load_bad;
    logic          at_max, at_zero;

    // Ripple increment/decrement across all digits in one cycle.
    always_comb begin
        inc_bcd = count_q;
        dec_bcd = count_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_bcd[4*i +: 4] = 4'd0;
                end else begin
                    inc_bcd[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_bcd[4*i +: 4] = 4'd9;
                end else begin
                    dec_bcd[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Load-value decode; 17 bits holds even an all-0xF value without wrapping.
    always_comb begin
        load_bin = '0;
        nib_bad  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            load_bin = (load_bin * 17'd10) + {13'd0, load_value_i[4*i +: 4]};
            if (load_value_i[4*i +: 4] > 4'd9) begin
                nib_bad = 1'b1;
            end
        end
        load_bad = nib_bad | (load_bin > 17'(MAX_COUNT));
    end

    assign at_max      = (count_q == MAX_BCD);
    assign at_zero     = (count_q == '0);
    assign overflow_o  = en_i & ~load_i & ~down_i & at_max;
    assign underflow_o = en_i & ~load_i & down_i & at_zero;
    assign load_err_o  = load_i & load_bad;

    always_comb begin
        count_d     = count_q;
        count_bin_d = count_bin_q;
        if (load_i) begin
            if (!load_bad) begin
                count_d     = load_value_i;
                count_bin_d = load_bin[BW-1:0];
            end
        end else if (en_i) begin
            if (!down_i) begin
                if (at_max) begin
                    count_d     = '0;
                    count_bin_d = '0;
                end else begin
                    count_d     = inc_bcd;
                    count_bin_d = count_bin_q + BW'(1);
                end
            end else begin
                if (at_zero) begin
                    count_d     = MAX_BCD;
                    count_bin_d = BW'(MAX_COUNT);
                end else begin
                    count_d     = dec_bcd;
                    count_bin_d = count_bin_q - BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q     <= '0;
            count_bin_q <= '0;
        end else begin
            count_q     <= count_d;
            count_bin_q <= count_bin_d;
        end
    end

    assign count_o     = count_q;
    assign count_bin_o = count_bin_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: vector table, integer reference model with random traffic,
// cascade of three stages and a three-digit direction-toggle instance.
module tb_bcd_updown_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       en, dn, ld;
    logic [7:0] ldv, cnt;
    logic [5:0] bin;
    logic       ovf, unf, lerr;

    logic       c_en, c_ld;
    logic [7:0] s_ldv, m_ldv, h_ldv, s_cnt, m_cnt, h_cnt;
    logic [5:0] s_bin, m_bin;
    logic [4:0] h_bin;
    logic       s_ovf, s_unf, s_err, m_ovf, m_unf, m_err, h_ovf, h_unf, h_err;

    logic        t_en, t_dn, t_ld;
    logic [11:0] t_ldv, t_cnt;
    logic [9:0]  t_bin;
    logic        t_ovf, t_unf, t_err;

    bcd_updown_counter #(.NUM_DIGITS(2), .MAX_COUNT(59)) u_main (
        .clk_i(clk), .rst_i(rst), .en_i(en), .down_i(dn), .load_i(ld), .load_value_i(ldv),
        .count_o(cnt), .count_bin_o(bin), .overflow_o(ovf), .underflow_o(unf), .load_err_o(lerr));

    bcd_updown_counter #(.NUM_DIGITS(2), .MAX_COUNT(59)) u_sec (
        .clk_i(clk), .rst_i(rst), .en_i(c_en), .down_i(1'b0), .load_i(c_ld), .load_value_i(s_ldv),
        .count_o(s_cnt), .count_bin_o(s_bin), .overflow_o(s_ovf), .underflow_o(s_unf), .load_err_o(s_err));

    bcd_updown_counter #(.NUM_DIGITS(2), .MAX_COUNT(59)) u_min (
        .clk_i(clk), .rst_i(rst), .en_i(s_ovf), .down_i(1'b0), .load_i(c_ld), .load_value_i(m_ldv),
        .count_o(m_cnt), .count_bin_o(m_bin), .overflow_o(m_ovf), .underflow_o(m_unf), .load_err_o(m_err));

    bcd_updown_counter #(.NUM_DIGITS(2), .MAX_COUNT(23)) u_hr (
        .clk_i(clk), .rst_i(rst), .en_i(m_ovf), .down_i(1'b0), .load_i(c_ld), .load_value_i(h_ldv),
        .count_o(h_cnt), .count_bin_o(h_bin), .overflow_o(h_ovf), .underflow_o(h_unf), .load_err_o(h_err));

    bcd_updown_counter #(.NUM_DIGITS(3), .MAX_COUNT(999)) u_tri (
        .clk_i(clk), .rst_i(rst), .en_i(t_en), .down_i(t_dn), .load_i(t_ld), .load_value_i(t_ldv),
        .count_o(t_cnt), .count_bin_o(t_bin), .overflow_o(t_ovf), .underflow_o(t_unf), .load_err_o(t_err));

    int tests  = 0;
    int failed = 0;
    int mc     = 0;

    typedef struct {
        bit       en;
        bit       dn;
        bit       ld;
        logic [7:0] ldv;
        logic [7:0] nxt;
        bit       ovf;
        bit       unf;
        bit       err;
    } vec_t;
    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int bcd_val(input logic [15:0] v, input int nd);
        int r = 0;
        for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'((v >> (4 * i)) & 16'hF);
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [15:0] v, input int nd, input int maxc);
        for (int i = 0; i < nd; i++) if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b0;
        return bcd_val(v, nd) <= maxc;
    endfunction

    function automatic logic [15:0] to_bcd(input int x, input int nd);
        logic [15:0] r = '0;
        int y = x;
        for (int i = 0; i < nd; i++) begin
            r = r | (16'(y % 10) << (4 * i));
            y = y / 10;
        end
        return r;
    endfunction

    function automatic int model_next(input int c, input bit e, input bit d, input bit l,
                                      input logic [15:0] v, input int nd, input int maxc);
        if (l) return bcd_ok(v, nd, maxc) ? bcd_val(v, nd) : c;
        if (!e) return c;
        if (!d) return (c == maxc) ? 0 : c + 1;
        return (c == 0) ? maxc : c - 1;
    endfunction

    // Checks current state and flags against the model, then advances one edge.
    task automatic cyc_main(input bit e, input bit d, input bit l, input logic [7:0] v, input string tag);
        logic [15:0] eb;
        en = e; dn = d; ld = l; ldv = v;
        #1;
        eb = to_bcd(mc, 2);
        chk({tag, " cnt"}, 32'(cnt), 32'(eb[7:0]));
        chk({tag, " bin"}, 32'(bin), 32'(mc));
        chk({tag, " ovf"}, 32'(ovf), 32'(e && !l && !d && mc == 59));
        chk({tag, " unf"}, 32'(unf), 32'(e && !l && d && mc == 0));
        chk({tag, " lerr"}, 32'(lerr), 32'(l && !bcd_ok({8'd0, v}, 2, 59)));
        mc = model_next(mc, e, d, l, {8'd0, v}, 2, 59);
        @(posedge clk); #2;
    endtask

    task automatic cyc_tri(input bit e, input bit d, input bit l, input logic [11:0] v,
                           input bit xo, input bit xu, input bit xe, input logic [11:0] nxt, input string tag);
        t_en = e; t_dn = d; t_ld = l; t_ldv = v;
        #1;
        chk({tag, " ovf"}, 32'(t_ovf), 32'(xo));
        chk({tag, " unf"}, 32'(t_unf), 32'(xu));
        chk({tag, " err"}, 32'(t_err), 32'(xe));
        @(posedge clk); #2;
        chk({tag, " cnt"}, 32'(t_cnt), 32'(nxt));
        chk({tag, " bin"}, 32'(t_bin), 32'(bcd_val({4'd0, nxt}, 3)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b1, 8'h45, 8'h45, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 8'h4A, 8'h45, 1'b0, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 8'h60, 8'h45, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h59, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h58, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b1, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b0, 1'b1, 8'h99, 8'h59, 1'b0, 1'b0, 1'b1};
        vt[15] = '{1'b0, 1'b0, 1'b1, 8'hF0, 8'h59, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        en = 0; dn = 0; ld = 0; ldv = '0;
        c_en = 0; c_ld = 0; s_ldv = '0; m_ldv = '0; h_ldv = '0;
        t_en = 0; t_dn = 0; t_ld = 0; t_ldv = '0;
        #3;
        chk("reset cnt", 32'(cnt), 32'h0);
        chk("reset bin", 32'(bin), 32'h0);
        chk("reset ovf", 32'(ovf), 32'h0);
        chk("reset unf", 32'(unf), 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            en = vt[i].en; dn = vt[i].dn; ld = vt[i].ld; ldv = vt[i].ldv;
            #1;
            chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vt[i].ovf));
            chk($sformatf("vec%0d unf", i), 32'(unf), 32'(vt[i].unf));
            chk($sformatf("vec%0d err", i), 32'(lerr), 32'(vt[i].err));
            @(posedge clk); #2;
            chk($sformatf("vec%0d cnt", i), 32'(cnt), 32'(vt[i].nxt));
            chk($sformatf("vec%0d bin", i), 32'(bin), 32'(bcd_val({8'd0, vt[i].nxt}, 2)));
        end
        mc = 59;

        cyc_main(1'b0, 1'b0, 1'b1, 8'h00, "sweep load");
        for (int i = 0; i < 61; i++) cyc_main(1'b1, 1'b0, 1'b0, 8'h00, $sformatf("up%0d", i));
        cyc_main(1'b0, 1'b0, 1'b1, 8'h10, "dn load10");
        cyc_main(1'b1, 1'b1, 1'b0, 8'h00, "dn 10");
        cyc_main(1'b0, 1'b0, 1'b1, 8'h00, "dn load00");
        cyc_main(1'b1, 1'b1, 1'b0, 8'h00, "dn 00");
        cyc_main(1'b0, 1'b0, 1'b0, 8'h00, "dn hold");

        for (int i = 0; i < 400; i++) begin
            logic [15:0] lb;
            logic [7:0]  v;
            lb = to_bcd(int'($urandom_range(0, 59)), 2);
            v  = ($urandom_range(0, 1) == 1) ? lb[7:0] : 8'($urandom);
            cyc_main(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), v, $sformatf("rnd%0d", i));
        end

        cyc_main(1'b0, 1'b0, 1'b1, 8'h37, "rst load37");
        en = 0; ld = 0;
        #1;
        chk("rst pre cnt", 32'(cnt), 32'h37);
        rst = 1'b1;
        #1;
        chk("rst async cnt", 32'(cnt), 32'h0);
        chk("rst async bin", 32'(bin), 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        mc = 0;
        cyc_main(1'b1, 1'b0, 1'b0, 8'h00, "post rst up");
        cyc_main(1'b0, 1'b0, 1'b0, 8'h00, "post rst hold");

        c_ld = 1; s_ldv = 8'h59; m_ldv = 8'h00; h_ldv = 8'h00;
        @(posedge clk); #2;
        c_ld = 0; c_en = 1;
        #1;
        chk("casc1 s_ovf", 32'(s_ovf), 32'h1);
        chk("casc1 m_ovf", 32'(m_ovf), 32'h0);
        @(posedge clk); #2;
        c_en = 0;
        chk("casc1 time", {8'd0, h_cnt, m_cnt, s_cnt}, 32'h000100);

        c_ld = 1; s_ldv = 8'h59; m_ldv = 8'h59; h_ldv = 8'h23;
        @(posedge clk); #2;
        c_ld = 0;
        #1;
        chk("casc2 loaded", {8'd0, h_cnt, m_cnt, s_cnt}, 32'h235959);
        chk("casc2 idle h_ovf", 32'(h_ovf), 32'h0);
        c_en = 1;
        #1;
        chk("casc2 s_ovf", 32'(s_ovf), 32'h1);
        chk("casc2 m_ovf", 32'(m_ovf), 32'h1);
        chk("casc2 h_ovf", 32'(h_ovf), 32'h1);
        @(posedge clk); #2;
        c_en = 0;
        #1;
        chk("casc2 time", {8'd0, h_cnt, m_cnt, s_cnt}, 32'h000000);
        chk("casc2 bins", {11'd0, h_bin, 4'd0, m_bin, 2'd0, s_bin}, 32'h0);
        chk("casc2 h_ovf after", 32'(h_ovf), 32'h0);

        cyc_tri(1'b0, 1'b0, 1'b1, 12'h100, 1'b0, 1'b0, 1'b0, 12'h100, "tri load100");
        cyc_tri(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h099, "tri tog1");
        cyc_tri(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h100, "tri tog2");
        cyc_tri(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h099, "tri tog3");
        cyc_tri(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h100, "tri tog4");
        cyc_tri(1'b0, 1'b0, 1'b1, 12'h999, 1'b0, 1'b0, 1'b0, 12'h999, "tri load999");
        cyc_tri(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, "tri wrap up");
        cyc_tri(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h999, "tri wrap dn");
        cyc_tri(1'b0, 1'b0, 1'b1, 12'h9A0, 1'b0, 1'b0, 1'b1, 12'h999, "tri bad load");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
